alu_cmd_issue: RTL
==================

// Module: alu_cmd_issue
// PURPOSE
//   Command issue and result-capture stage wrapped around the combinational ALU.
//   Buffers {op,A,B} commands from a valid/ready producer in a FIFO.
//   Drives the ALU operand and select inputs from registers, then captures
//   Dataout/Compare into a result register with a valid/ready handshake.
//   Drops illegal opcodes and counts them.
// PARAMETERS
//   N        2       operand/result width; matches the ALU's N
//   DEPTH    4       command FIFO entries (power of two, >=2)
//   CNT_W    8       width of illegal-op counter
// PORTS
//   clk          in   1      single clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   cmd_valid    in   1      producer has a command
//   cmd_ready    out  1      FIFO can accept (= !full)
//   cmd_op       in   3      001 XOR, 010 INCA, 100 LT; others illegal
//   cmd_a        in   N      operand A
//   cmd_b        in   N      operand B
//   alu_a        out  N      registered ALU input A
//   alu_b        out  N      registered ALU input B
//   alu_sel      out  3      registered ALU Select
//   alu_dataout  in   N      ALU Dataout (combinational from alu_a/b/sel)
//   alu_compare  in   1      ALU Compare
//   res_valid    out  1      result register holds a result
//   res_ready    in   1      consumer accepts result
//   res_data     out  N      captured Dataout (0 for LT)
//   res_cmp      out  1      captured Compare (0 for XOR/INCA)
//   res_op       out  3      opcode of the captured result
//   illegal_cnt  out  CNT_W  saturating count of dropped illegal commands
// BEHAVIOUR
//   Reset (async, rst_n=0): FIFO empty, state IDLE, alu_a/b/sel=0, res_valid=0,
//     res_data/res_cmp/res_op=0, illegal_cnt=0, cmd_ready=1 once rst_n=1.
//     Reset mid-operation flushes the FIFO and any in-flight or held result.
//   Push: cmd_valid&&cmd_ready at an edge writes the command to the FIFO tail.
//     No bypass: a command is issued at the earliest one edge after its push.
//     Push and pop in the same cycle are allowed; count is unchanged.
//   slot_free = !res_valid || res_ready.
//   FSM IDLE:
//     - FIFO empty: stay IDLE.
//     - Head op illegal: pop, illegal_cnt+=1 (saturate at all-ones), stay IDLE.
//       No ALU access and no result. The pop does not wait on slot_free.
//     - Head op legal && slot_free: pop; load alu_a/b/sel from head; go to EXEC.
//     - Head op legal && !slot_free: hold.
//   FSM EXEC (one cycle; ALU outputs settle from the registered inputs):
//     - At the edge: res_data = (op==LT) ? 0 : alu_dataout;
//       res_cmp = (op==LT) ? alu_compare : 0; res_op = op; res_valid = 1.
//     - Go to IDLE.
//     - The slot is guaranteed free because only EXEC fills it.
//   alu_a/b/sel hold their last issued values in IDLE.
//   Result handshake: res_valid&&res_ready at an edge clears res_valid unless
//     EXEC captures at that same edge. res_* stay stable while res_valid && !res_ready.
//   Latency: push at edge E0 into an empty FIFO -> issue E1 -> res_valid=1 after E2.
//   Throughput: one legal command per 2 cycles.
//   Arithmetic: none in this block. INCA wraps per the ALU (N=2: 3+1 -> 0).
//   Full: cmd_ready=0 when count==DEPTH. Empty: no issue.
//   The FIFO count uses a wrap-safe pointer with log2(DEPTH)+1 bits.
//   No X leaves the block: ALU X outputs for unused fields are masked to 0.
// TESTING
//   1 reset, then push {XOR,a=2'b10,b=2'b11} with res_ready=1
//     -> alu_sel=001 one edge after push; res_valid=1, res_data=01, res_cmp=0 one edge later.
//   2 push INCA a=3 -> res_data=00 (wrap), res_op=010; push LT a=1,b=2 -> res_cmp=1, res_data=0.
//   3 hold res_ready=0, push 5 legal cmds -> one result held stable, 4 entries
//     queued, cmd_ready=0. Release res_ready -> 5 results in push order.
//   4 push op=3'b111 then XOR -> illegal_cnt=1, no result for 111,
//     XOR result appears. Push 256 illegal ops -> illegal_cnt stays 255.
//   5 assert rst_n=0 during EXEC with 3 queued -> all outputs 0 immediately,
//     no result emitted after release, cmd_ready=1.
//   6 random valid/ready backpressure, 1000 cmds vs reference model
//     -> exact in-order match, no X on res_*.

Source files
------------

// File: rtl/alu_cmd_issue.sv
// Command issue / result capture stage around a combinational ALU.
// Commands queue in a FIFO, issue through registered ALU inputs, and results land in a valid/ready register.
module alu_cmd_issue #(
  parameter int N     = 2,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [N-1:0]     cmd_a,
  input  logic [N-1:0]     cmd_b,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  output logic [2:0]       alu_sel,
  input  logic [N-1:0]     alu_dataout,
  input  logic             alu_compare,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [N-1:0]     res_data,
  output logic             res_cmp,
  output logic [2:0]       res_op,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] OP_XOR  = 3'b001;
  localparam logic [2:0] OP_INCA = 3'b010;
  localparam logic [2:0] OP_LT   = 3'b100;
  localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {S_IDLE = 1'b0, S_EXEC = 1'b1} state_t;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid and its payload stay stable until that edge, ready may change freely.

  logic [2:0]   op_mem [DEPTH];
  logic [N-1:0] a_mem  [DEPTH];
  logic [N-1:0] b_mem  [DEPTH];

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  state_t           state_q, state_d;
  logic [N-1:0]     alu_a_q, alu_b_q;
  logic [2:0]       alu_sel_q;
  logic             res_valid_q;
  logic [N-1:0]     res_data_q;
  logic             res_cmp_q;
  logic [2:0]       res_op_q;
  logic [CNT_W-1:0] illegal_cnt_q;

  logic       fifo_full, fifo_empty, push;
  logic [2:0] head_op;
  logic       head_legal, slot_free;
  logic       pop, issue, drop, capture;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && !fifo_full;

  assign head_op    = op_mem[rd_ptr_q[AW-1:0]];
  assign head_legal = (head_op == OP_XOR) || (head_op == OP_INCA) || (head_op == OP_LT);
  assign slot_free  = !res_valid_q || res_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr_q[AW-1:0]] <= cmd_op;
      a_mem[wr_ptr_q[AW-1:0]]  <= cmd_a;
      b_mem[wr_ptr_q[AW-1:0]]  <= cmd_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (!fifo_empty && head_legal && slot_free) state_d = S_EXEC;
      S_EXEC: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Illegal heads are discarded without waiting for the result slot.
  always_comb begin
    drop    = 1'b0;
    issue   = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        drop  = !fifo_empty && !head_legal;
        issue = !fifo_empty && head_legal && slot_free;
      end
      S_EXEC: capture = 1'b1;
      default: ;
    endcase
    pop = drop || issue;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_sel_q     <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_cmp_q     <= 1'b0;
      res_op_q      <= '0;
      illegal_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (issue) begin
        alu_a_q   <= a_mem[rd_ptr_q[AW-1:0]];
        alu_b_q   <= b_mem[rd_ptr_q[AW-1:0]];
        alu_sel_q <= head_op;
      end
      if (drop && (illegal_cnt_q != CNT_MAX)) illegal_cnt_q <= illegal_cnt_q + CNT_ONE;
      // The unused ALU field for each op is masked so X never reaches the result.
      if (capture) begin
        res_valid_q <= 1'b1;
        res_data_q  <= (alu_sel_q == OP_LT) ? '0 : alu_dataout;
        res_cmp_q   <= (alu_sel_q == OP_LT) ? alu_compare : 1'b0;
        res_op_q    <= alu_sel_q;
      end else if (res_valid_q && res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_sel     = alu_sel_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_cmp     = res_cmp_q;
  assign res_op      = res_op_q;
  assign illegal_cnt = illegal_cnt_q;

endmodule
